// File: rtl/axi_xbar_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_xbar_pkg
//  Purpose  : Shared AXI crossbar constants and queue-entry types.
//  Revision : 1.0  initial release
// ============================================================================
package axi_xbar_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   // Entry layouts for the default configuration (4-bit IDs, 64-word memory)
   localparam int XBAR_ID_W  = 4;
   localparam int XBAR_IDX_W = 6;

   typedef struct packed {
      logic [XBAR_IDX_W-1:0] widx;
      logic [3:0]            len;
      logic [XBAR_ID_W-1:0]  id;
      logic [1:0]            burst;
   } aw_entry_t;

   typedef struct packed {
      logic [XBAR_ID_W-1:0] id;
      logic [1:0]           resp;
   } b_entry_t;

endpackage
`default_nettype wire

// File: rtl/axi_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : axi_sync_fifo
//  Purpose  : Single-clock FIFO with occupancy count and synchronous clear.
//  Revision : 1.0  initial release
// ============================================================================
module axi_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     srst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int                 c_PTR_W = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]   c_FULL  = DEPTH[c_PTR_W:0];

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_count;
   logic               w_push;
   logic               w_pop;

   assign w_push   = push && !full;
   assign w_pop    = pop && !empty;
   assign full     = (r_count == c_FULL);
   assign empty    = (r_count == '0);
   assign count    = r_count;
   assign pop_data = r_mem[r_rd_ptr];

   // Storage is cleared too so the head reads zero while empty after reset
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (srst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/axi_slv_wr_responder.sv
`default_nettype none
// ============================================================================
//  Module   : axi_slv_wr_responder
//  Purpose  : AXI3 write slave: AW queue, strobed memory writes, in-order B.
//  Revision : 1.0  initial release
// ============================================================================
module axi_slv_wr_responder
   import axi_xbar_pkg::*;
#(
   parameter int AXI_ADDR_W      = 32,
   parameter int AXI_ID_W        = 4,
   parameter int AXI_DATA_W      = 32,
   parameter int SLV_OSTDREQ_NUM = 4,
   parameter int MEM_DEPTH       = 64
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic                         srst,
   input  logic                         awvalid,
   output logic                         awready,
   input  logic [AXI_ADDR_W-1:0]        awaddr,
   input  logic [3:0]                   awlen,
   input  logic [AXI_ID_W-1:0]          awid,
   input  logic [1:0]                   awburst,
   input  logic                         wvalid,
   output logic                         wready,
   input  logic                         wlast,
   input  logic [AXI_ID_W-1:0]          wid,
   input  logic [AXI_DATA_W-1:0]        wdata,
   input  logic [AXI_DATA_W/8-1:0]      wstrb,
   output logic                         bvalid,
   input  logic                         bready,
   output logic [AXI_ID_W-1:0]          bid,
   output logic [1:0]                   bresp,
   input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
   output logic [AXI_DATA_W-1:0]        dbg_rdata
);

   localparam int c_BYTE_W = $clog2(AXI_DATA_W/8);
   localparam int c_IDX_W  = $clog2(MEM_DEPTH);
   localparam int c_STRB_W = AXI_DATA_W/8;
   localparam int c_CNT_W  = $clog2(SLV_OSTDREQ_NUM) + 1;
   localparam logic [c_CNT_W-1:0] c_B_MAX = SLV_OSTDREQ_NUM[c_CNT_W-1:0];

   typedef struct packed {
      logic [c_IDX_W-1:0]  widx;
      logic [3:0]          len;
      logic [AXI_ID_W-1:0] id;
      logic [1:0]          burst;
   } slv_aw_t;

   typedef struct packed {
      logic [AXI_ID_W-1:0] id;
      logic [1:0]          resp;
   } slv_b_t;

   slv_aw_t              w_aw_push_data;
   slv_aw_t              w_aw_head;
   logic                 w_aw_full;
   logic                 w_aw_empty;
   logic                 w_aw_push;
   logic                 w_aw_pop;
   logic [c_CNT_W-1:0]   w_aw_cnt_unused;
   slv_b_t               w_b_push_data;
   slv_b_t               w_b_head;
   logic                 w_b_full_unused;
   logic                 w_b_empty;
   logic                 w_b_pop;
   logic [c_CNT_W-1:0]   w_b_cnt;
   logic                 w_w_hs;
   logic                 w_last_beat;
   logic                 w_beat_err;
   logic [c_IDX_W-1:0]   w_widx;
   logic                 w_unused;

   logic                 r_rst_done;
   logic [3:0]           r_beat_cnt;
   logic                 r_err;
   logic [AXI_DATA_W-1:0] r_mem [MEM_DEPTH];

   assign w_unused = ^awaddr;

   assign awready        = r_rst_done && !w_aw_full;
   assign w_aw_push      = awvalid && awready;
   assign w_aw_push_data = '{widx: awaddr[c_BYTE_W +: c_IDX_W], len: awlen,
                             id: awid, burst: awburst};

   axi_sync_fifo #(.WIDTH($bits(slv_aw_t)), .DEPTH(SLV_OSTDREQ_NUM)) u_aw_fifo (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .srst      (srst),
      .push      (w_aw_push),
      .push_data (w_aw_push_data),
      .pop       (w_aw_pop),
      .pop_data  (w_aw_head),
      .full      (w_aw_full),
      .empty     (w_aw_empty),
      .count     (w_aw_cnt_unused)
   );

   // Beat length comes from the queued awlen; wlast only feeds the error flag
   assign wready      = !w_aw_empty && (w_b_cnt < c_B_MAX);
   assign w_w_hs      = wvalid && wready;
   assign w_last_beat = (r_beat_cnt == w_aw_head.len);
   assign w_beat_err  = (wlast != w_last_beat) || (wid != w_aw_head.id) ||
                        (w_aw_head.burst != BURST_INCR);
   assign w_widx      = w_aw_head.widx + c_IDX_W'(r_beat_cnt);
   assign w_aw_pop    = w_w_hs && w_last_beat;

   assign w_b_push_data = '{id: w_aw_head.id,
                            resp: (r_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY};
   assign w_b_pop       = bvalid && bready;

   axi_sync_fifo #(.WIDTH($bits(slv_b_t)), .DEPTH(SLV_OSTDREQ_NUM)) u_b_fifo (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .srst      (srst),
      .push      (w_aw_pop),
      .push_data (w_b_push_data),
      .pop       (w_b_pop),
      .pop_data  (w_b_head),
      .full      (w_b_full_unused),
      .empty     (w_b_empty),
      .count     (w_b_cnt)
   );

   assign bvalid = !w_b_empty;
   assign bid    = w_b_head.id;
   assign bresp  = w_b_head.resp;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_rst_done <= 1'b0;
         r_beat_cnt <= '0;
         r_err      <= 1'b0;
      end else if (srst) begin
         r_rst_done <= 1'b0;
         r_beat_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         r_rst_done <= 1'b1;
         if (w_w_hs) begin
            if (w_last_beat) begin
               r_beat_cnt <= '0;
               r_err      <= 1'b0;
            end else begin
               r_beat_cnt <= r_beat_cnt + 1'b1;
               r_err      <= r_err || w_beat_err;
            end
         end
      end
   end

   // Memory survives srst; a beat coinciding with srst belongs to a discarded burst
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
      end else if (w_w_hs && !srst && (w_aw_head.burst == BURST_INCR)) begin
         for (int b = 0; b < c_STRB_W; b++) begin
            if (wstrb[b]) r_mem[w_widx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   assign dbg_rdata = r_mem[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_axi_slv_wr_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_slv_wr_responder
//  Purpose  : Scoreboard bench for axi_slv_wr_responder with a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_slv_wr_responder;

   localparam int DEPTH = 64;
   localparam int LIMIT = 400;

   logic        aclk    = 1'b0;
   logic        aresetn = 1'b0;
   logic        srst    = 1'b0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] awaddr  = '0;
   logic [3:0]  awlen   = '0;
   logic [3:0]  awid    = '0;
   logic [1:0]  awburst = 2'b01;
   logic        wvalid  = 1'b0;
   logic        wready;
   logic        wlast   = 1'b0;
   logic [3:0]  wid     = '0;
   logic [31:0] wdata   = '0;
   logic [3:0]  wstrb   = '0;
   logic        bvalid;
   logic        bready  = 1'b0;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic [5:0]  dbg_addr = '0;
   logic [31:0] dbg_rdata;

   always #5 aclk = ~aclk;

   axi_slv_wr_responder #(
      .AXI_ADDR_W(32), .AXI_ID_W(4), .AXI_DATA_W(32),
      .SLV_OSTDREQ_NUM(4), .MEM_DEPTH(DEPTH)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .srst(srst),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
      .awid(awid), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wlast(wlast), .wid(wid),
      .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
      .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
   );

   typedef struct packed {
      logic [31:0]       addr;
      logic [3:0]        len;
      logic [3:0]        id;
      logic [1:0]        burst;
      logic [15:0][31:0] data;
      logic [15:0][3:0]  strb;
      logic [15:0]       last;
      logic [15:0][3:0]  wid;
   } burst_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } bexp_t;

   bexp_t       exp_q[$];
   burst_t      pend_q[$];
   logic [31:0] mem_model [DEPTH];
   int          checks      = 0;
   int          failures    = 0;
   int          bready_mode = 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout required=handshake", name);
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   function automatic burst_t make_burst(input logic [31:0] addr, input logic [3:0] len,
                                         input logic [3:0] id);
      burst_t b;
      b.addr  = addr;
      b.len   = len;
      b.id    = id;
      b.burst = 2'b01;
      for (int i = 0; i < 16; i++) begin
         b.data[i] = $urandom;
         b.strb[i] = 4'hF;
         b.last[i] = (i == int'(len));
         b.wid[i]  = id;
      end
      return b;
   endfunction

   function automatic burst_t random_burst();
      burst_t b;
      int     k;
      b = make_burst($urandom, 4'($urandom % 16), 4'($urandom));
      for (int i = 0; i < 16; i++) b.strb[i] = 4'($urandom);
      k = $urandom % (int'(b.len) + 1);
      if ($urandom % 6 == 0) b.last[k] = ~b.last[k];
      if ($urandom % 8 == 0) b.wid[k] = b.id ^ 4'h1;
      if ($urandom % 8 == 0) begin
         b.burst = 2'($urandom % 4);
         if (b.burst == 2'b01) b.burst = 2'b11;
      end
      return b;
   endfunction

   // A burst errs if it is not INCR, or any beat has a wrong wlast or wid
   function automatic logic [1:0] model_resp(input burst_t b);
      bit err;
      err = (b.burst != 2'b01);
      for (int i = 0; i <= int'(b.len); i++) begin
         if (b.last[i] != (i == int'(b.len))) err = 1'b1;
         if (b.wid[i] != b.id) err = 1'b1;
      end
      return err ? 2'b10 : 2'b00;
   endfunction

   task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
      for (int k = 0; k < 4; k++)
         if (strb[k]) mem_model[idx % DEPTH][k*8 +: 8] = data[k*8 +: 8];
   endtask

   task automatic send_aw(input burst_t b);
      bexp_t e;
      int    n;
      e.id   = b.id;
      e.resp = model_resp(b);
      exp_q.push_back(e);
      pend_q.push_back(b);
      awvalid = 1'b1; awaddr = b.addr; awlen = b.len; awid = b.id; awburst = b.burst;
      n = 0;
      @(negedge aclk);
      while (!awready && n < LIMIT) begin
         @(negedge aclk);
         n++;
      end
      if (!awready) fail_timeout("aw_handshake");
      @(posedge aclk);
      #1;
      awvalid = 1'b0;
   endtask

   task automatic send_burst(input int nbeats);
      burst_t b;
      int     n;
      if (pend_q.size() == 0) begin
         fail_timeout("no_pending_burst");
         return;
      end
      b = pend_q.pop_front();
      for (int i = 0; i <= int'(b.len) && i < nbeats; i++) begin
         wvalid = 1'b1; wdata = b.data[i]; wstrb = b.strb[i]; wlast = b.last[i]; wid = b.wid[i];
         n = 0;
         @(negedge aclk);
         while (!wready && n < LIMIT) begin
            @(negedge aclk);
            n++;
         end
         if (!wready) begin
            fail_timeout("w_handshake");
            wvalid = 1'b0;
            return;
         end
         if (b.burst == 2'b01) model_write(int'((b.addr / 4) % DEPTH) + i, b.data[i], b.strb[i]);
         @(posedge aclk);
         #1;
         if (i < int'(b.len) && i < nbeats - 1 && $urandom % 4 == 0) begin
            wvalid = 1'b0;
            step();
         end
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < LIMIT * 4) begin
         step();
         n++;
      end
      if (exp_q.size() != 0) fail_timeout("b_drain");
      step();
      step();
   endtask

   task automatic check_mem(input string name);
      for (int i = 0; i < DEPTH; i++) begin
         dbg_addr = 6'(i);
         @(negedge aclk);
         check(name, dbg_rdata, mem_model[i]);
      end
      step();
   endtask

   initial begin
      forever begin
         @(posedge aclk);
         #2;
         case (bready_mode)
            0:       bready = 1'b0;
            1:       bready = 1'b1;
            default: bready = ($urandom % 3) != 0;
         endcase
      end
   end

   initial begin : monitor
      bexp_t e;
      forever begin
         @(negedge aclk);
         if (aresetn && bvalid && bready) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL b_unexpected actual bid=%0d bresp=%0d required none", bid, bresp);
            end else begin
               e = exp_q.pop_front();
               check("bid", 32'(bid), 32'(e.id));
               check("bresp", 32'(bresp), 32'(e.resp));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin : main
      burst_t b;
      for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;

      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("rst_awready", 32'(awready), 0);
      check("rst_wready", 32'(wready), 0);
      check("rst_bvalid", 32'(bvalid), 0);
      check("rst_bid", 32'(bid), 0);
      check("rst_bresp", 32'(bresp), 0);
      step();
      aresetn = 1'b1;
      @(negedge aclk);
      check("awready_release_cycle", 32'(awready), 0);
      step();
      @(negedge aclk);
      check("awready_after_release", 32'(awready), 1);
      check("wready_no_aw", 32'(wready), 0);
      step();

      b = make_burst(32'h10, 4'd3, 4'd5);
      send_aw(b);
      send_burst(16);
      @(negedge aclk);
      check("b_latency", 32'(bvalid), 1);
      step();
      wait_drain();
      check_mem("mem_incr4");

      b = make_burst(32'h40, 4'd1, 4'd2);
      b.last[0] = 1'b1;
      send_aw(b);
      send_burst(16);
      wait_drain();

      b = make_burst(32'h0, 4'd0, 4'd3);
      b.data[0] = 32'hAABBCCDD;
      send_aw(b);
      send_burst(16);
      b = make_burst(32'h0, 4'd0, 4'd3);
      b.data[0] = 32'h11223344;
      b.strb[0] = 4'b0101;
      send_aw(b);
      send_burst(16);
      wait_drain();
      dbg_addr = 6'd0;
      @(negedge aclk);
      check("strb_merge", dbg_rdata, 32'hAA22CC44);
      step();

      b = make_burst(32'((DEPTH - 1) * 4), 4'd1, 4'd7);
      send_aw(b);
      send_burst(16);
      wait_drain();
      check_mem("mem_wrap");

      for (int k = 0; k < 4; k++) send_aw(make_burst(32'(k * 16), 4'd1, 4'(k + 8)));
      fork
         send_aw(make_burst(32'h80, 4'd2, 4'hC));
         begin
            repeat (3) begin
               @(negedge aclk);
               check("aw_full_ready", 32'(awready), 0);
            end
            step();
            send_burst(16);
         end
      join
      for (int k = 0; k < 4; k++) send_burst(16);
      wait_drain();
      check_mem("mem_aw_full");

      bready_mode = 0;
      step();
      step();
      for (int k = 0; k < 4; k++) begin
         send_aw(make_burst(32'(32 + k * 8), 4'(k), 4'(k + 1)));
         send_burst(16);
      end
      send_aw(make_burst(32'h60, 4'd0, 4'hF));
      repeat (3) begin
         @(negedge aclk);
         check("b_full_wready", 32'(wready), 0);
      end
      check("b_hold_bid", 32'(bid), 1);
      step();
      bready_mode = 1;
      send_burst(16);
      wait_drain();

      bready_mode = 2;
      fork
         begin : aw_gen
            burst_t rb;
            for (int k = 0; k < 40; k++) begin
               rb = random_burst();
               send_aw(rb);
               repeat ($urandom % 3) step();
            end
         end
         begin : w_gen
            int n;
            for (int k = 0; k < 40; k++) begin
               n = 0;
               while (pend_q.size() == 0 && n < LIMIT) begin
                  step();
                  n++;
               end
               send_burst(16);
            end
         end
      join
      bready_mode = 1;
      wait_drain();
      check_mem("mem_random");

      b = make_burst(32'hC0, 4'd3, 4'd6);
      send_aw(b);
      send_burst(2);
      void'(exp_q.pop_back());
      srst = 1'b1;
      step();
      srst = 1'b0;
      @(negedge aclk);
      check("srst_bvalid", 32'(bvalid), 0);
      check("srst_awready", 32'(awready), 0);
      repeat (5) step();
      @(negedge aclk);
      check("srst_no_b", 32'(bvalid), 0);
      step();
      check_mem("mem_srst");

      b = make_burst(32'h0, 4'd3, 4'd9);
      send_aw(b);
      send_burst(2);
      void'(exp_q.pop_back());
      aresetn  = 1'b0;
      dbg_addr = 6'd0;
      for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
      @(negedge aclk);
      check("arst_bvalid", 32'(bvalid), 0);
      check("arst_awready", 32'(awready), 0);
      check("arst_mem0", dbg_rdata, 0);
      step();
      aresetn = 1'b1;
      repeat (4) step();
      @(negedge aclk);
      check("arst_no_b", 32'(bvalid), 0);
      step();
      check_mem("mem_areset");

      check("exp_queue_empty", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
